// File: rtl/bidir_bus_turnaround_ctrl.sv
// Direction controller for one bidirectional data bus: turnaround bubbles, registered pads,
// input capture pipeline and switch statistics. Define BIDIR_READBACK_CHK_EN to build the readback check.
module bidir_bus_turnaround_ctrl #(
    parameter int DW        = 16,
    parameter int TURN_CYC  = 1,
    parameter int IN_STAGES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drv_req,
    input  logic [DW-1:0]    drv_data,
    output logic             drv_ready,
    output logic [DW-1:0]    rx_data,
    output logic             rx_valid,
    input  logic [DW-1:0]    pad_i,
    output logic [DW-1:0]    pad_o,
    output logic             pad_oe,
    output logic [CNT_W-1:0] switch_cnt,
    output logic             rb_err
);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_r;
    logic [3:0]        turn_cnt_r;
    logic [DW-1:0]     pad_o_r;
    logic              pad_oe_r;
    logic [CNT_W-1:0]  switch_cnt_r;
    logic [DW-1:0]     cap_data_r [IN_STAGES];
    logic [IN_STAGES-1:0] cap_tag_r;
    logic              tag_s;

    // Direction state machine with registered pad outputs and switch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RX;
            turn_cnt_r   <= 4'd0;
            pad_o_r      <= {DW{1'b0}};
            pad_oe_r     <= 1'b0;
            switch_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RX: begin
                    pad_oe_r <= 1'b0;
                    if (drv_req) begin
                        state_r    <= ST_TURN_TX;
                        turn_cnt_r <= TURN_LOAD;
                        if (switch_cnt_r != CNT_MAX) begin
                            switch_cnt_r <= switch_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_TURN_TX: begin
                    pad_oe_r <= 1'b0;
                    if (turn_cnt_r == 4'd0) begin
                        state_r <= ST_TX;
                    end else begin
                        turn_cnt_r <= turn_cnt_r - 4'd1;
                    end
                end
                ST_TX: begin
                    // Accepting a beat is the only way pad_oe is raised for the next cycle
                    if (drv_req) begin
                        pad_o_r  <= drv_data;
                        pad_oe_r <= 1'b1;
                    end else begin
                        pad_oe_r   <= 1'b0;
                        state_r    <= ST_TURN_RX;
                        turn_cnt_r <= TURN_LOAD;
                    end
                end
                ST_TURN_RX: begin
                    pad_oe_r <= 1'b0;
                    if (turn_cnt_r == 4'd0) begin
                        state_r <= ST_RX;
                    end else begin
                        turn_cnt_r <= turn_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= ST_RX;
                    pad_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign tag_s = (state_r == ST_RX) && !pad_oe_r;

    // Input capture pipeline; the released-bus tag travels alongside the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_STAGES; i++) begin
                cap_data_r[i] <= {DW{1'b0}};
            end
            cap_tag_r <= {IN_STAGES{1'b0}};
        end else begin
            cap_data_r[0] <= pad_i;
            cap_tag_r[0]  <= tag_s;
            for (int i = 1; i < IN_STAGES; i++) begin
                cap_data_r[i] <= cap_data_r[i-1];
                cap_tag_r[i]  <= cap_tag_r[i-1];
            end
        end
    end

    assign drv_ready  = (state_r == ST_TX);
    assign pad_o      = pad_o_r;
    assign pad_oe     = pad_oe_r;
    assign switch_cnt = switch_cnt_r;
    assign rx_data    = cap_data_r[IN_STAGES-1];
    assign rx_valid   = cap_tag_r[IN_STAGES-1];

`ifdef BIDIR_READBACK_CHK_EN
    logic [DW-1:0] rb_pad_i_r;
    logic [DW-1:0] rb_pad_o_r;
    logic          rb_oe_r;
    logic          rb_err_r;

    function automatic logic rb_mismatch(input logic [DW-1:0] seen, input logic [DW-1:0] driven);
        return |(seen ^ driven);
    endfunction

    // Compare last cycle's pad sample with what was driven then, only inside back-to-back drive cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_pad_i_r <= {DW{1'b0}};
            rb_pad_o_r <= {DW{1'b0}};
            rb_oe_r    <= 1'b0;
            rb_err_r   <= 1'b0;
        end else begin
            rb_pad_i_r <= pad_i;
            rb_pad_o_r <= pad_o_r;
            rb_oe_r    <= pad_oe_r;
            if (pad_oe_r && rb_oe_r && rb_mismatch(rb_pad_i_r, rb_pad_o_r)) begin
                rb_err_r <= 1'b1;
            end
        end
    end

    assign rb_err = rb_err_r;
`else
    assign rb_err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_bus_turnaround_ctrl.sv
// Bench for bidir_bus_turnaround_ctrl: directed table, corner sequences and a timestamp-based
// reference model under random traffic. Follows BIDIR_READBACK_CHK_EN for rb_err expectations.
module tb_bidir_bus_turnaround_ctrl;

    localparam int DW        = 16;
    localparam int TURN_CYC  = 2;
    localparam int IN_STAGES = 1;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef BIDIR_READBACK_CHK_EN
    localparam bit RB_ON = 1'b1;
`else
    localparam bit RB_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             drv_req;
    logic [DW-1:0]    drv_data;
    logic             drv_ready;
    logic [DW-1:0]    rx_data;
    logic             rx_valid;
    logic [DW-1:0]    pad_i;
    logic [DW-1:0]    pad_o;
    logic             pad_oe;
    logic [CNT_W-1:0] switch_cnt;
    logic             rb_err;

    bidir_bus_turnaround_ctrl #(
        .DW(DW), .TURN_CYC(TURN_CYC), .IN_STAGES(IN_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drv_req(drv_req), .drv_data(drv_data),
        .drv_ready(drv_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
        .switch_cnt(switch_cnt), .rb_err(rb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic [DW-1:0] pin;
        logic          e_ready;
        logic          e_oe;
        logic [DW-1:0] e_pado;
        logic          e_valid;
        logic [DW-1:0] e_rxd;
        logic [3:0]    e_cnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          t;
    } hist_t;

    vec_t  tbl [11];
    hist_t hist_q [$];

    // Reference model: bus ownership expressed as timestamps of when drive/release windows open
    int            n;
    bit            m_mode;      // 0: heading to / in released, 1: heading to / in driving
    int            m_idle_at;
    int            m_ready_at;
    bit            m_oe;
    logic [DW-1:0] m_pado;
    int            m_cnt;
    bit            m_rb;
    bit            m_prev_oe;
    logic [DW-1:0] m_prev_pin;
    logic [DW-1:0] m_prev_pado;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_model();
        hist_t h;
        chk("drv_ready", drv_ready, (m_mode && n >= m_ready_at));
        chk("pad_oe", pad_oe, m_oe);
        chk("pad_o", pad_o, m_pado);
        chk("switch_cnt", switch_cnt, m_cnt);
        chk("rb_err", rb_err, m_rb);
        if (hist_q.size() == IN_STAGES) begin
            h = hist_q[0];
            chk("rx_valid", rx_valid, h.t);
            chk("rx_data", rx_data, h.d);
        end else begin
            chk("rx_valid", rx_valid, 1'b0);
            chk("rx_data", rx_data, 16'h0000);
        end
    endtask

    task automatic step(input logic req, input logic [DW-1:0] data, input logic [DW-1:0] pin);
        bit    cur_idle;
        bit    cur_ready;
        bit    accept;
        hist_t h;
        drv_req  = req;
        drv_data = data;
        pad_i    = pin;
        cur_idle  = !m_mode && (n >= m_idle_at);
        cur_ready = m_mode && (n >= m_ready_at);
        if (hist_q.size() == IN_STAGES) void'(hist_q.pop_front());
        h.d = pin;
        h.t = cur_idle && !m_oe;
        hist_q.push_back(h);
        if (RB_ON && m_oe && m_prev_oe && (m_prev_pin != m_prev_pado)) m_rb = 1'b1;
        m_prev_oe   = m_oe;
        m_prev_pin  = pin;
        m_prev_pado = m_pado;
        accept = cur_ready && req;
        if (cur_idle && req) begin
            m_mode     = 1'b1;
            m_ready_at = n + 1 + TURN_CYC;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (cur_ready && !req) begin
            m_mode    = 1'b0;
            m_idle_at = n + 1 + TURN_CYC;
        end
        m_oe = accept;
        if (accept) m_pado = data;
        @(posedge clk);
        #1;
        n++;
        check_model();
    endtask

    function automatic logic [DW-1:0] loop_pin();
        return m_oe ? m_pado : DW'($urandom);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        drv_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_async_pad_oe", pad_oe, 1'b0);
        chk("rst_async_rx_valid", rx_valid, 1'b0);
        chk("rst_async_drv_ready", drv_ready, 1'b0);
        chk("rst_async_switch_cnt", switch_cnt, 4'd0);
        chk("rst_async_rb_err", rb_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_mode = 1'b0; m_idle_at = 0; m_ready_at = 0; m_oe = 1'b0;
        m_pado = 16'h0000; m_cnt = 0; m_rb = 1'b0;
        m_prev_oe = 1'b0; m_prev_pin = 16'h0000; m_prev_pado = 16'h0000;
        hist_q.delete();
        check_model();
    endtask

    initial begin
        bit req_prev;
        logic [DW-1:0] pin;
        int seq4 [20] = '{1,1,1,1,1,0,1,1,1,1,1,1,1,1,1,0,0,0,0,0};

        rst_n = 1'b0; drv_req = 1'b0; drv_data = 16'h0000; pad_i = 16'hA5A5; n = 0;
        repeat (2) @(posedge clk);

        // Idle capture, drive latency, 4-beat burst, release bubble
        tbl[0]  = '{1'b1, 16'd1, 16'hA5A5, 1'b0, 1'b0, 16'd0, 1'b1, 16'hA5A5, 4'd1};
        tbl[1]  = '{1'b1, 16'd1, 16'hA5A5, 1'b0, 1'b0, 16'd0, 1'b0, 16'hA5A5, 4'd1};
        tbl[2]  = '{1'b1, 16'd1, 16'hA5A5, 1'b1, 1'b0, 16'd0, 1'b0, 16'hA5A5, 4'd1};
        tbl[3]  = '{1'b1, 16'd1, 16'hA5A5, 1'b1, 1'b1, 16'd1, 1'b0, 16'hA5A5, 4'd1};
        tbl[4]  = '{1'b1, 16'd2, 16'h0001, 1'b1, 1'b1, 16'd2, 1'b0, 16'h0001, 4'd1};
        tbl[5]  = '{1'b1, 16'd3, 16'h0002, 1'b1, 1'b1, 16'd3, 1'b0, 16'h0002, 4'd1};
        tbl[6]  = '{1'b1, 16'd4, 16'h0003, 1'b1, 1'b1, 16'd4, 1'b0, 16'h0003, 4'd1};
        tbl[7]  = '{1'b0, 16'd0, 16'h0004, 1'b0, 1'b0, 16'd4, 1'b0, 16'h0004, 4'd1};
        tbl[8]  = '{1'b0, 16'd0, 16'hA5A5, 1'b0, 1'b0, 16'd4, 1'b0, 16'hA5A5, 4'd1};
        tbl[9]  = '{1'b0, 16'd0, 16'hA5A5, 1'b0, 1'b0, 16'd4, 1'b0, 16'hA5A5, 4'd1};
        tbl[10] = '{1'b0, 16'd0, 16'hA5A5, 1'b0, 1'b0, 16'd4, 1'b1, 16'hA5A5, 4'd1};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drv_req  = tbl[i].req;
            drv_data = tbl[i].data;
            pad_i    = tbl[i].pin;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_drv_ready", i), drv_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_pad_oe", i), pad_oe, tbl[i].e_oe);
            chk($sformatf("tbl%0d_pad_o", i), pad_o, tbl[i].e_pado);
            chk($sformatf("tbl%0d_rx_valid", i), rx_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_rx_data", i), rx_data, tbl[i].e_rxd);
            chk($sformatf("tbl%0d_switch_cnt", i), switch_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_rb_err", i), rb_err, 1'b0);
        end

        // One-cycle gap inside TX, with requests ignored during the release bubble
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(seq4[i][0], DW'($urandom), loop_pin());
        end
        chk("gap_switch_cnt", switch_cnt, 4'd2);

        // Counter saturation
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), loop_pin());
            for (int i = 0; i < 5; i++) step(1'b0, DW'($urandom), loop_pin());
        end
        chk("sat_switch_cnt", switch_cnt, 4'd15);

        // Readback fault on bit 3 during a burst, sticky until reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pin = loop_pin();
            if (i == 5) pin = m_pado ^ 16'h0008;
            step(1'b1, DW'($urandom), pin);
        end
        for (int i = 0; i < 6; i++) step(1'b0, DW'($urandom), loop_pin());
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), loop_pin());
        chk("rb_err_sticky", rb_err, RB_ON);
        do_reset();
        chk("rb_err_cleared", rb_err, 1'b0);

        // Random traffic with rare pad faults and occasional resets
        req_prev = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit req;
            req = ($urandom_range(0, 99) < (req_prev ? 80 : 30));
            pin = loop_pin();
            if (m_oe && $urandom_range(0, 199) == 0) pin = m_pado ^ DW'(1 << $urandom_range(0, DW - 1));
            step(req, DW'($urandom), pin);
            req_prev = req;
            if ((i % 400) == 399) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
